// File: rtl/ms_game_ctrl.sv
// rtl/ms_game_ctrl.sv - minesweeper gameplay sequencer and sole writer of the tile-state RAM
module ms_game_ctrl #(
  parameter int          HORI_TILES = 20,
  parameter int          VERT_TILES = 15,
  parameter int          MINE_COUNT = 40,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_press,
  input  logic       btn_flag,
  input  logic       vblank,
  output logic       tile_en,
  output logic       tile_we,
  output logic [8:0] tile_addr,
  output logic [6:0] tile_wdata,
  input  logic [6:0] tile_rdata,
  output logic [4:0] cur_x,
  output logic [3:0] cur_y,
  output logic [1:0] game_state,
  output logic       busy
);

  localparam int         TILES     = HORI_TILES * VERT_TILES;
  localparam logic [8:0] LAST_TILE = 9'(TILES - 1);
  localparam logic [8:0] LAST_MINE = 9'(MINE_COUNT - 1);
  localparam logic [8:0] LAST_SAFE = 9'(TILES - MINE_COUNT - 1);
  localparam logic [4:0] X_MAX     = 5'(HORI_TILES - 1);
  localparam logic [3:0] Y_MAX     = 4'(VERT_TILES - 1);

  localparam logic [1:0] GS_INIT    = 2'd0;
  localparam logic [1:0] GS_PLAYING = 2'd1;
  localparam logic [1:0] GS_LOST    = 2'd2;
  localparam logic [1:0] GS_WON     = 2'd3;

  typedef enum logic [3:0] {
    S_CLEAR, S_PLACE, S_PLACE_CHK, S_IDLE, S_F_READ, S_F_CHK,
    S_R_READ, S_R_CHK, S_SCAN, S_R_WRITE, S_END
  } state_t;

  state_t      state, state_n;
  logic [5:0]  s1, s2, prev, ev;
  logic        ev_left, ev_right, ev_up, ev_down, ev_press, ev_flag;
  logic [15:0] lfsr;
  logic [1:0]  gs, gs_n;
  logic [4:0]  cx, tgt_x, nb_x;
  logic [3:0]  cy, tgt_y, nb_y;
  logic [8:0]  clr_idx, placed, place_addr, revealed_cnt, tgt_addr, nb_addr;
  logic [2:0]  nb_idx;
  logic [3:0]  count, count_acc;
  logic        rd_pend, nb_pend, run, go;
  logic [6:0]  rd_q, rd_val;
  logic        dx_dec, dx_inc, dy_dec, dy_inc, nb_ok;
  logic        clr_inc, place_rd, place_hit, play_start, latch_tgt;
  logic        scan_start, nb_adv, nb_rd, reveal_inc, restart;

  // Release-edge detection on the synchronised buttons
  assign ev = prev & ~s2;
  assign {ev_left, ev_right, ev_up, ev_down, ev_press, ev_flag} = ev;

  assign go        = vblank & run;
  assign rd_val    = rd_pend ? tile_rdata : rd_q;
  assign count_acc = count + {3'b000, nb_pend & tile_rdata[4]};
  assign tgt_addr  = 9'(tgt_y) * 9'(HORI_TILES) + 9'(tgt_x);
  assign nb_addr   = 9'(nb_y) * 9'(HORI_TILES) + 9'(nb_x);

  assign cur_x      = cx;
  assign cur_y      = cy;
  assign game_state = gs;
  assign busy       = !(state == S_IDLE || state == S_END);

  always_comb begin
    dx_dec = 1'b0;
    dx_inc = 1'b0;
    dy_dec = 1'b0;
    dy_inc = 1'b0;
    case (nb_idx)
      3'd0: begin dx_dec = 1'b1; dy_dec = 1'b1; end
      3'd1: dy_dec = 1'b1;
      3'd2: begin dx_inc = 1'b1; dy_dec = 1'b1; end
      3'd3: dx_dec = 1'b1;
      3'd4: dx_inc = 1'b1;
      3'd5: begin dx_dec = 1'b1; dy_inc = 1'b1; end
      3'd6: dy_inc = 1'b1;
      default: begin dx_inc = 1'b1; dy_inc = 1'b1; end
    endcase
    nb_ok = !(dx_dec && tgt_x == 5'd0) && !(dx_inc && tgt_x == X_MAX) &&
            !(dy_dec && tgt_y == 4'd0) && !(dy_inc && tgt_y == Y_MAX);
    nb_x  = dx_dec ? tgt_x - 5'd1 : (dx_inc ? tgt_x + 5'd1 : tgt_x);
    nb_y  = dy_dec ? tgt_y - 4'd1 : (dy_inc ? tgt_y + 4'd1 : tgt_y);
  end

  always_comb begin
    state_n    = state;
    gs_n       = gs;
    tile_en    = 1'b0;
    tile_we    = 1'b0;
    tile_addr  = 9'd0;
    tile_wdata = 7'd0;
    clr_inc    = 1'b0;
    place_rd   = 1'b0;
    place_hit  = 1'b0;
    play_start = 1'b0;
    latch_tgt  = 1'b0;
    scan_start = 1'b0;
    nb_adv     = 1'b0;
    nb_rd      = 1'b0;
    reveal_inc = 1'b0;
    restart    = 1'b0;
    case (state)
      S_CLEAR: if (go) begin
        tile_en   = 1'b1;
        tile_we   = 1'b1;
        tile_addr = clr_idx;
        clr_inc   = 1'b1;
        if (clr_idx == LAST_TILE) state_n = S_PLACE;
      end
      S_PLACE: if (go && lfsr[8:0] <= LAST_TILE) begin
        tile_en   = 1'b1;
        tile_addr = lfsr[8:0];
        place_rd  = 1'b1;
        state_n   = S_PLACE_CHK;
      end
      S_PLACE_CHK: if (go) begin
        state_n = S_PLACE;
        if (!rd_val[4]) begin
          tile_en    = 1'b1;
          tile_we    = 1'b1;
          tile_addr  = place_addr;
          tile_wdata = 7'b0010000;
          place_hit  = 1'b1;
          if (placed == LAST_MINE) begin
            gs_n       = GS_PLAYING;
            play_start = 1'b1;
            state_n    = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (ev_press) begin
          latch_tgt = 1'b1;
          state_n   = S_R_READ;
        end else if (ev_flag) begin
          latch_tgt = 1'b1;
          state_n   = S_F_READ;
        end
      end
      S_F_READ: if (go) begin
        tile_en   = 1'b1;
        tile_addr = tgt_addr;
        state_n   = S_F_CHK;
      end
      S_F_CHK: begin
        if (rd_val[6]) begin
          state_n = S_IDLE;
        end else if (go) begin
          tile_en    = 1'b1;
          tile_we    = 1'b1;
          tile_addr  = tgt_addr;
          tile_wdata = rd_val ^ 7'b0100000;
          state_n    = S_IDLE;
        end
      end
      S_R_READ: if (go) begin
        tile_en   = 1'b1;
        tile_addr = tgt_addr;
        state_n   = S_R_CHK;
      end
      S_R_CHK: begin
        if (rd_val[6] || rd_val[5]) begin
          state_n = S_IDLE;
        end else if (rd_val[4]) begin
          if (go) begin
            tile_en    = 1'b1;
            tile_we    = 1'b1;
            tile_addr  = tgt_addr;
            tile_wdata = rd_val | 7'b1000000;
            gs_n       = GS_LOST;
            state_n    = S_END;
          end
        end else begin
          scan_start = 1'b1;
          state_n    = S_SCAN;
        end
      end
      // Off-grid neighbours are skipped without waiting for vblank
      S_SCAN: begin
        if (!nb_ok) begin
          nb_adv = 1'b1;
          if (nb_idx == 3'd7) state_n = S_R_WRITE;
        end else if (go) begin
          tile_en   = 1'b1;
          tile_addr = nb_addr;
          nb_adv    = 1'b1;
          nb_rd     = 1'b1;
          if (nb_idx == 3'd7) state_n = S_R_WRITE;
        end
      end
      S_R_WRITE: if (go) begin
        tile_en    = 1'b1;
        tile_we    = 1'b1;
        tile_addr  = tgt_addr;
        tile_wdata = {3'b100, count_acc};
        reveal_inc = 1'b1;
        if (revealed_cnt == LAST_SAFE) begin
          gs_n    = GS_WON;
          state_n = S_END;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_END: if (ev_press) begin
        gs_n    = GS_INIT;
        restart = 1'b1;
        state_n = S_CLEAR;
      end
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      lfsr         <= LFSR_SEED;
      state        <= S_CLEAR;
      gs           <= GS_INIT;
      cx           <= '0;
      cy           <= '0;
      clr_idx      <= '0;
      placed       <= '0;
      place_addr   <= '0;
      revealed_cnt <= '0;
      tgt_x        <= '0;
      tgt_y        <= '0;
      nb_idx       <= '0;
      count        <= '0;
      rd_pend      <= 1'b0;
      nb_pend      <= 1'b0;
      rd_q         <= '0;
      run          <= 1'b0;
    end else begin
      s1      <= {btn_left, btn_right, btn_up, btn_down, btn_press, btn_flag};
      s2      <= s1;
      prev    <= s2;
      lfsr    <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      state   <= state_n;
      gs      <= gs_n;
      run     <= 1'b1;
      rd_pend <= tile_en & ~tile_we;
      nb_pend <= nb_rd;
      if (rd_pend) rd_q <= tile_rdata;

      if (gs == GS_PLAYING) begin
        if (ev_left)       cx <= (cx == 5'd0) ? X_MAX : cx - 5'd1;
        else if (ev_right) cx <= (cx == X_MAX) ? 5'd0 : cx + 5'd1;
        if (ev_up)         cy <= (cy == 4'd0) ? Y_MAX : cy - 4'd1;
        else if (ev_down)  cy <= (cy == Y_MAX) ? 4'd0 : cy + 4'd1;
      end

      if (restart)      clr_idx <= '0;
      else if (clr_inc) clr_idx <= clr_idx + 9'd1;
      if (restart)        placed <= '0;
      else if (place_hit) placed <= placed + 9'd1;
      if (place_rd) place_addr <= lfsr[8:0];
      if (play_start)      revealed_cnt <= '0;
      else if (reveal_inc) revealed_cnt <= revealed_cnt + 9'd1;
      if (latch_tgt) begin
        tgt_x <= cx;
        tgt_y <= cy;
      end
      if (scan_start) begin
        nb_idx <= '0;
        count  <= '0;
      end else begin
        if (nb_adv)  nb_idx <= nb_idx + 3'd1;
        if (nb_pend) count  <= count_acc;
      end
    end
  end

endmodule

// File: tb/tb_ms_game_ctrl.sv
// tb/tb_ms_game_ctrl.sv - scoreboard bench for ms_game_ctrl with a behavioural tile RAM
module tb_ms_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btns;
  logic       vblank;
  logic       tile_en, tile_we;
  logic [8:0] tile_addr;
  logic [6:0] tile_wdata;
  logic [6:0] tile_rdata = '0;
  logic [4:0] cur_x;
  logic [3:0] cur_y;
  logic [1:0] game_state;
  logic       busy;

  logic [6:0] ram [0:511];
  logic       bw_en = 1'b0;
  logic [8:0] bw_addr = '0;
  logic [6:0] bw_data = '0;

  int  vb_mode = 0;
  int  ph = 0;
  bit  sb_on = 1'b0;
  logic [15:0] exp_q [$];
  int  n_checks = 0, n_err = 0;
  int  en_cnt = 0, viol = 0;
  int  clr_cnt = 0, clr_exp = 0, clr_bad = 0, mine_cnt = 0, other_cnt = 0;
  int  cx = 0, cy = 0;
  bit  live = 1'b0;

  localparam logic [5:0] B_L = 6'b100000, B_R = 6'b010000, B_U = 6'b001000;
  localparam logic [5:0] B_D = 6'b000100, B_P = 6'b000010, B_F = 6'b000001;

  ms_game_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btns[5]), .btn_right(btns[4]), .btn_up(btns[3]),
    .btn_down(btns[2]), .btn_press(btns[1]), .btn_flag(btns[0]),
    .vblank(vblank),
    .tile_en(tile_en), .tile_we(tile_we), .tile_addr(tile_addr),
    .tile_wdata(tile_wdata), .tile_rdata(tile_rdata),
    .cur_x(cur_x), .cur_y(cur_y), .game_state(game_state), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bw_en) ram[bw_addr] <= bw_data;
    else if (tile_en) begin
      if (tile_we) ram[tile_addr] <= tile_wdata;
      else tile_rdata <= ram[tile_addr];
    end
  end

  // vblank changes just after the rising edge so it is stable at the sampling edge
  initial begin
    vblank = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 5;
      vblank = (vb_mode == 1) ? 1'b1 : (vb_mode == 2) ? (ph < 3) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tile_en) en_cnt++;
    if (tile_en && !vblank) viol++;
    if (tile_en && tile_we) begin
      if (sb_on) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ram_write unexpected actual addr=%0d data=%b, required none", tile_addr, tile_wdata);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if ({tile_addr, tile_wdata} !== e) begin
            n_err++;
            $display("FAIL ram_write actual addr=%0d data=%b, required addr=%0d data=%b",
                     tile_addr, tile_wdata, e[15:7], e[6:0]);
          end
        end
      end else begin
        if (tile_wdata == 7'd0) begin
          if (int'(tile_addr) != clr_exp) clr_bad++;
          clr_cnt++;
          clr_exp++;
        end else if (tile_wdata == 7'h10) mine_cnt++;
        else other_cnt++;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic pulse(input logic [5:0] m);
    btns = m;
    repeat (3) @(negedge clk);
    btns = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", int'(busy), 0);
  endtask

  task automatic wait_gs(input int g, input int bound);
    int n = 0;
    while (int'(game_state) != g && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("game_state_wait", int'(game_state), g);
  endtask

  task automatic act(input logic [5:0] m);
    pulse(m);
    wait_idle();
  endtask

  task automatic mv(input logic [5:0] m);
    pulse(m);
    if (live) begin
      if (m[5])      cx = (cx == 0) ? 19 : cx - 1;
      else if (m[4]) cx = (cx == 19) ? 0 : cx + 1;
      if (m[3])      cy = (cy == 0) ? 14 : cy - 1;
      else if (m[2]) cy = (cy == 14) ? 0 : cy + 1;
    end
    check("cur_x", int'(cur_x), cx);
    check("cur_y", int'(cur_y), cy);
  endtask

  function automatic bit is_mine(input int kind, input int a);
    if (kind == 0) return (a == 84 || a == 106 || a == 125);
    return (a >= 260);
  endfunction

  task automatic load_layout(input int kind);
    for (int a = 0; a < 300; a++) begin
      @(negedge clk);
      bw_en   = 1'b1;
      bw_addr = 9'(a);
      bw_data = is_mine(kind, a) ? 7'h10 : 7'h00;
    end
    @(negedge clk);
    bw_en = 1'b0;
  endtask

  function automatic int nbc(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 20 && y + dy >= 0 && y + dy < 15)
          if (is_mine(1, (y + dy) * 20 + x + dx)) c++;
    return c;
  endfunction

  task automatic push_exp(input int a, input logic [6:0] d);
    exp_q.push_back({9'(a), d});
  endtask

  task automatic reset_stats();
    clr_cnt = 0; clr_exp = 0; clr_bad = 0; mine_cnt = 0; other_cnt = 0;
  endtask

  task automatic check_setup();
    int m = 0;
    check("clear_writes", clr_cnt, 300);
    check("clear_order_errors", clr_bad, 0);
    check("mine_writes", mine_cnt, 40);
    check("other_writes", other_cnt, 0);
    for (int a = 0; a < 300; a++) if (ram[a] == 7'h10) m++;
    check("distinct_mines", m, 40);
    @(negedge clk);
    check("busy_playing", int'(busy), 0);
  endtask

  initial begin
    logic [6:0] d;
    btns  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cur_x", int'(cur_x), 0);
    check("rst_cur_y", int'(cur_y), 0);
    check("rst_game_state", int'(game_state), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_tile_en", int'(tile_en), 0);
    check("rst_tile_we", int'(tile_we), 0);
    check("rst_tile_addr", int'(tile_addr), 0);
    check("rst_tile_wdata", int'(tile_wdata), 0);
    rst_n = 1'b1;

    repeat (10000) @(negedge clk);
    check("no_en_outside_vblank", en_cnt, 0);
    check("held_game_state", int'(game_state), 0);
    check("held_busy", int'(busy), 1);
    vb_mode = 1;
    wait_gs(1, 20000);
    check_setup();

    load_layout(0);
    sb_on = 1'b1;
    live  = 1'b1;
    mv(B_L);
    mv(B_U);
    mv(B_L | B_R);
    mv(B_U | B_D);
    mv(B_R); mv(B_R);
    mv(B_D); mv(B_D);
    mv(B_R); mv(B_R);

    push_exp(2, 7'b0100000);
    act(B_F);
    act(B_P);
    push_exp(2, 7'b0000000);
    act(B_F);
    check("drain_flag", exp_q.size(), 0);

    repeat (3) mv(B_R);
    repeat (5) mv(B_D);
    vb_mode = 2;
    push_exp(105, 7'b1000011);
    act(B_P);
    repeat (5) @(negedge clk);
    vb_mode = 1;
    act(B_F);
    check("drain_reveal", exp_q.size(), 0);

    mv(B_L);
    mv(B_U);
    push_exp(84, 7'b1010000);
    act(B_P);
    check("lost_state", int'(game_state), 2);
    check("lost_busy", int'(busy), 0);
    live = 1'b0;
    mv(B_L);
    check("drain_lost", exp_q.size(), 0);

    sb_on = 1'b0;
    reset_stats();
    pulse(B_P);
    check("restart_state", int'(game_state), 0);
    check("restart_busy", int'(busy), 1);
    wait_gs(1, 20000);
    check_setup();

    live = 1'b1;
    load_layout(1);
    sb_on = 1'b1;
    repeat (4) mv(B_L);
    repeat (4) mv(B_U);
    for (int a = 0; a < 260; a++) begin
      d = {3'b100, 4'(nbc(cx, cy))};
      push_exp(cy * 20 + cx, d);
      act(B_P);
      check("reveal_state", int'(game_state), (a == 259) ? 3 : 1);
      if (a < 259) begin
        mv(B_R);
        if (cx == 0) mv(B_D);
      end
    end
    check("drain_won", exp_q.size(), 0);
    check("en_vblank_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
